// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage of the five-stage pipeline plus the MEM/WB
// pipeline register. Performs little-endian word/halfword/byte stores with
// alignment checking and registers the load word, ALU result and write-back
// control for the register file.
module mem_wb_stage #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wrn,
    input  logic [31:0] ddpc4,
    input  logic [31:0] dbusw,
    input  logic [31:0] ddata2,
    input  logic [4:0]  drw,
    input  logic        nnreg_write,
    input  logic        nnmem_write,
    input  logic [1:0]  nns_data_write,
    input  logic        mmemtoreg,
    output logic [31:0] wpc4,
    output logic [31:0] walu,
    output logic [31:0] wmem,
    output logic [4:0]  wrw,
    output logic        wreg_write,
    output logic        wmemtoreg,
    output logic        wexc,
    output logic [31:0] wb_data
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] index;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic              err;
    logic              store_en;
    logic [3:0]        be;
    logic [31:0]       wdata;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
    assign index   = dbusw[ADDR_W+1:2];
    assign lane    = dbusw[1:0];
    assign rd_word = mem[index];

    // Alignment / encoding error for the instruction currently in MEM.
    always_comb begin
        err = 1'b0;
        if (nnmem_write) begin
            case (nns_data_write)
                2'b00:   err = (lane != 2'b00);
                2'b01:   err = lane[0];
                2'b10:   err = 1'b0;
                default: err = 1'b1;
            endcase
        end
        if (mmemtoreg && (lane != 2'b00))
            err = 1'b1;
    end

    // Byte-lane enables and replicated store data for each store size.
    always_comb begin
        be    = 4'b0000;
        wdata = ddata2;
        case (nns_data_write)
            2'b00: be = 4'b1111;
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{ddata2[15:0]}};
            end
            2'b10: begin
                be    = 4'b0001 << lane;
                wdata = {4{ddata2[7:0]}};
            end
            default: be = 4'b0000;
        endcase
    end

    // A reset held across an edge cancels the store on that edge.
    assign store_en = nnmem_write & wrn & ~err & ~reset;

    // Data memory: no reset, contents persist; unselected lanes keep their bytes.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && be[i])
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // MEM/WB pipeline register; holds everything while wrn is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wpc4       <= 32'h0;
            walu       <= 32'h0;
            wmem       <= 32'h0;
            wrw        <= 5'h0;
            wreg_write <= 1'b0;
            wmemtoreg  <= 1'b0;
            wexc       <= 1'b0;
        end else if (wrn) begin
            wpc4       <= ddpc4;
            walu       <= dbusw;
            wmem       <= rd_word;
            wrw        <= drw;
            wreg_write <= nnreg_write & ~err;
            wmemtoreg  <= mmemtoreg;
            wexc       <= err;
        end
    end

    assign wb_data = wmemtoreg ? wmem : walu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. A reference memory
// model predicts each instruction's MEM/WB contents when it is driven; the
// prediction is popped and compared after the edge that registers it.
module tb_mem_wb_stage;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wrn = 1'b0;
    logic [31:0] ddpc4 = '0, dbusw = '0, ddata2 = '0;
    logic [4:0]  drw = '0;
    logic        nnreg_write = 1'b0, nnmem_write = 1'b0, mmemtoreg = 1'b0;
    logic [1:0]  nns_data_write = '0;
    logic [31:0] wpc4, walu, wmem, wb_data;
    logic [4:0]  wrw;
    logic        wreg_write, wmemtoreg, wexc;

    mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .wrn(wrn),
        .ddpc4(ddpc4), .dbusw(dbusw), .ddata2(ddata2), .drw(drw),
        .nnreg_write(nnreg_write), .nnmem_write(nnmem_write),
        .nns_data_write(nns_data_write), .mmemtoreg(mmemtoreg),
        .wpc4(wpc4), .walu(walu), .wmem(wmem), .wrw(wrw),
        .wreg_write(wreg_write), .wmemtoreg(wmemtoreg), .wexc(wexc),
        .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] mdat;
        logic        known;
        logic [4:0]  rw;
        logic        reg_write;
        logic        m2r;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    logic [31:0] mdl [DEPTH];
    logic        mk  [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        chk({tag, ".wpc4"}, wpc4, e.pc4);
        chk({tag, ".walu"}, walu, e.alu);
        chk({tag, ".wrw"}, {27'h0, wrw}, {27'h0, e.rw});
        chk({tag, ".wreg_write"}, {31'h0, wreg_write}, {31'h0, e.reg_write});
        chk({tag, ".wmemtoreg"}, {31'h0, wmemtoreg}, {31'h0, e.m2r});
        chk({tag, ".wexc"}, {31'h0, wexc}, {31'h0, e.exc});
        if (e.known) chk({tag, ".wmem"}, wmem, e.mdat);
        if (e.known || !e.m2r) chk({tag, ".wb_data"}, wb_data, e.m2r ? e.mdat : e.alu);
    endtask

    // Drive one cycle of stimulus, predict the result, then check after the edge.
    task automatic step(input string tag, input logic en, input logic [31:0] pc4,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rw,
                        input logic rwe, input logic mwe, input logic [1:0] sz, input logic m2r);
        logic                  err;
        logic [ADDR_W-1:0]     idx;
        exp_t                  e;
        exp_t                  got;
        logic [31:0]           w;
        wrn = en; ddpc4 = pc4; dbusw = alu; ddata2 = sd; drw = rw;
        nnreg_write = rwe; nnmem_write = mwe; nns_data_write = sz; mmemtoreg = m2r;
        idx = alu[ADDR_W+1:2];
        err = (mwe && sz == 2'b00 && alu[1:0] != 2'b00) || (mwe && sz == 2'b01 && alu[0])
              || (mwe && sz == 2'b11) || (m2r && alu[1:0] != 2'b00);
        if (en) begin
            e.pc4 = pc4; e.alu = alu; e.mdat = mdl[idx]; e.known = mk[idx];
            e.rw = rw; e.reg_write = rwe && !err; e.m2r = m2r; e.exc = err;
            sb_q.push_back(e);
            if (mwe && !err) begin
                w = mdl[idx];
                case (sz)
                    2'b00: begin w = sd; mk[idx] = 1'b1; end
                    2'b01: if (alu[1]) w[31:16] = sd[15:0]; else w[15:0] = sd[15:0];
                    default: w[8*alu[1:0] +: 8] = sd[7:0];
                endcase
                mdl[idx] = w;
            end
        end
        @(posedge clock);
        #1;
        if (en) begin
            got = sb_q.pop_front();
            last = got;
        end
        check_regs(tag, last);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = '0;
            mk[i]  = 1'b0;
        end
        last = '{pc4: 0, alu: 0, mdat: 0, known: 1'b1, rw: 0, reg_write: 0, m2r: 0, exc: 0};

        reset = 1'b1;
        #12;
        check_regs("rst_init", last);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Word store then load back.
        step("st_w40", 1, 32'h104, 32'h40, 32'h12345678, 5'd0, 0, 1, 2'b00, 0);
        step("ld_w40", 1, 32'h108, 32'h40, 32'h0, 5'd5, 1, 0, 2'b00, 1);
        // Sub-word stores into a preloaded word.
        step("st_ff", 1, 32'h10c, 32'h40, 32'hFFFFFFFF, 5'd0, 0, 1, 2'b00, 0);
        step("st_b42", 1, 32'h110, 32'h42, 32'h000000AB, 5'd0, 0, 1, 2'b10, 0);
        step("ld_b42", 1, 32'h114, 32'h40, 32'h0, 5'd6, 1, 0, 2'b00, 1);
        chk("mem_after_byte", wmem, 32'hFFABFFFF);
        step("st_h40", 1, 32'h118, 32'h40, 32'hAAAA1234, 5'd0, 0, 1, 2'b01, 0);
        step("st_h42", 1, 32'h11c, 32'h44, 32'h0, 5'd0, 0, 1, 2'b00, 0);
        step("st_h46", 1, 32'h120, 32'h46, 32'h0000BEEF, 5'd0, 0, 1, 2'b01, 0);
        step("ld_h40", 1, 32'h124, 32'h40, 32'h0, 5'd7, 1, 0, 2'b00, 1);
        chk("mem_after_half", wmem, 32'hFFAB1234);
        step("ld_h44", 1, 32'h128, 32'h44, 32'h0, 5'd8, 1, 0, 2'b00, 1);
        // Misalignment and reserved size.
        step("st_h41", 1, 32'h12c, 32'h41, 32'h00005555, 5'd0, 1, 1, 2'b01, 0);
        step("st_w42", 1, 32'h130, 32'h42, 32'h66666666, 5'd0, 0, 1, 2'b00, 0);
        step("st_sz3", 1, 32'h134, 32'h40, 32'h77777777, 5'd0, 0, 1, 2'b11, 0);
        step("ld_w46", 1, 32'h138, 32'h46, 32'h0, 5'd9, 1, 0, 2'b00, 1);
        step("ld_chk40", 1, 32'h13c, 32'h40, 32'h0, 5'd10, 1, 0, 2'b00, 1);
        chk("mem_after_misalign", wmem, 32'hFFAB1234);
        // Stall: store presented with wrn low, then released.
        step("pre_80", 1, 32'h140, 32'h80, 32'h0, 5'd0, 0, 1, 2'b00, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 32'h144, 32'h80, 32'h55, 5'd0, 0, 1, 2'b00, 0);
        step("st_80", 1, 32'h144, 32'h80, 32'h55, 5'd0, 0, 1, 2'b00, 0);
        step("ld_80", 1, 32'h148, 32'h80, 32'h0, 5'd11, 1, 0, 2'b00, 1);
        step("ld_80b", 1, 32'h14c, 32'h80, 32'h0, 5'd12, 1, 0, 2'b00, 1);
        chk("mem_after_stall", wmem, 32'h55);
        // Address wrap.
        step("st_wrap", 1, 32'h150, 32'h1000, 32'h77, 5'd0, 0, 1, 2'b00, 0);
        step("ld_w0", 1, 32'h154, 32'h0, 32'h0, 5'd13, 1, 0, 2'b00, 1);
        step("alu_1000", 1, 32'h158, 32'h1000, 32'h0, 5'd14, 1, 0, 2'b00, 0);
        chk("wrap_alu", wb_data, 32'h1000);
        // Reset mid-cycle with nonzero registers; memory survives, held-reset store cancelled.
        step("st_10", 1, 32'h15c, 32'h10, 32'hCAFEBABE, 5'd0, 0, 1, 2'b00, 0);
        step("nz_regs", 1, 32'h160, 32'h10, 32'h0, 5'd31, 1, 0, 2'b00, 1);
        wrn = 1'b1; nnmem_write = 1'b1; nns_data_write = 2'b00; ddata2 = 32'hDEADDEAD;
        mmemtoreg = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        last = '{pc4: 0, alu: 0, mdat: 0, known: 1'b1, rw: 0, reg_write: 0, m2r: 0, exc: 0};
        check_regs("rst_async", last);
        @(posedge clock);
        #1;
        check_regs("rst_hold", last);
        @(negedge clock);
        reset = 1'b0;
        nnmem_write = 1'b0;
        wrn = 1'b0;
        step("ld_10", 1, 32'h164, 32'h10, 32'h0, 5'd15, 1, 0, 2'b00, 1);
        chk("mem_survives_reset", wmem, 32'hCAFEBABE);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
